// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset level,
// opcode constants and the fetch FSM state type.
package if_fetch_pkg;

    localparam int STALL_W     = 6;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic                   RST_ENABLE = 1'b1;
    localparam logic [INST_W-1:0]      ZERO_WORD  = '0;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_predecode.sv
// Static branch predictor on a buffered instruction: JAL and backward
// conditional branches are predicted taken, everything else falls through.
module if_predecode
    import if_fetch_pkg::*;
#(
    parameter bit PREDICT_EN = 1'b1
) (
    input  logic [INST_W-1:0]      inst_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    output logic                   pred_o,
    output logic [INST_ADDR_W-1:0] next_pc_o
);

    logic [INST_ADDR_W-1:0] j_imm;
    logic [INST_ADDR_W-1:0] b_imm;

    assign j_imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign b_imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

    // Select prediction and next fetch PC; inst[31] is the branch offset sign bit.
    always_comb begin
        pred_o    = 1'b0;
        next_pc_o = pc_i + 32'd4;
        if (PREDICT_EN) begin
            if (inst_i[6:0] == OP_JAL) begin
                pred_o    = 1'b1;
                next_pc_o = pc_i + j_imm;
            end else if (inst_i[6:0] == OP_BRANCH && inst_i[31]) begin
                pred_o    = 1'b1;
                next_pc_o = pc_i + b_imm;
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one word request at a
// time, buffers the returned instruction and presents it to IF/ID.
// Handshake: mem_req is held high with a stable mem_addr until a one-cycle
// mem_valid pulse returns the word; toward IF/ID the instruction is offered
// while if_stall_req=0 and is taken on the edge where stall_sign[0]=0.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          PREDICT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic [STALL_W-1:0]     stall_sign,
    input  logic                   ex_jump,
    input  logic [INST_ADDR_W-1:0] ex_target,
    output logic                   mem_req,
    output logic [INST_ADDR_W-1:0] mem_addr,
    input  logic                   mem_valid,
    input  logic [INST_W-1:0]      mem_inst,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   if_taken,
    output logic                   if_stall_req,
    output logic [1:0]             dbg_state_o
);

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0]      buf_q, buf_d;
    // A word returned while rdy=0 is parked here until the stage unfreezes.
    logic                   got_q, got_d;
    logic                   arrive;
    logic                   pred;
    logic [INST_ADDR_W-1:0] next_pc;
    logic                   unused_stall;

    assign unused_stall = ^stall_sign[STALL_W-1:1];
    assign arrive       = mem_valid || got_q;

    if_predecode #(
        .PREDICT_EN(PREDICT_EN)
    ) u_predecode (
        .inst_i    (buf_q),
        .pc_i      (pc_q),
        .pred_o    (pred),
        .next_pc_o (next_pc)
    );

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= ZERO_WORD;
            buf_q   <= ZERO_WORD;
            got_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            got_q   <= got_d;
        end
    end

    // Next-state logic: freeze (except data capture), then redirect, then normal flow.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        got_d   = got_q;
        if (!rdy) begin
            if (mem_valid && !got_q && (state_q == ST_WAIT || state_q == ST_DISCARD)) begin
                got_d = 1'b1;
                buf_d = mem_inst;
            end
        end else if (ex_jump) begin
            got_d = 1'b0;
            pc_d  = word_align(ex_target);
            case (state_q)
                ST_WAIT, ST_DISCARD: begin
                    // An outstanding request must complete before a new one issues.
                    if (arrive) begin
                        state_d = ST_WAIT;
                        addr_d  = pc_d;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    addr_d  = pc_d;
                end
            endcase
        end else begin
            got_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    addr_d  = pc_q;
                end
                ST_WAIT: begin
                    if (arrive) begin
                        state_d = ST_HOLD;
                        if (mem_valid) buf_d = mem_inst;
                    end
                end
                ST_HOLD: begin
                    if (!stall_sign[0]) begin
                        pc_d    = next_pc;
                        addr_d  = next_pc;
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    if (arrive) begin
                        state_d = ST_WAIT;
                        addr_d  = pc_q;
                    end
                end
            endcase
        end
    end

    // Output decode: only HOLD presents a real instruction, otherwise a bubble.
    always_comb begin
        if_inst      = ZERO_WORD;
        if_pc        = ZERO_WORD;
        if_taken     = 1'b0;
        if_stall_req = 1'b1;
        if (state_q == ST_HOLD) begin
            if_inst      = buf_q;
            if_pc        = pc_q;
            if_taken     = pred;
            if_stall_req = 1'b0;
        end
    end

    assign mem_req     = (state_q == ST_WAIT || state_q == ST_DISCARD) && !got_q;
    assign mem_addr    = addr_q;
    assign dbg_state_o = state_q;

endmodule
